// File: rtl/bus_pkg.sv
// Shared encodings and sizing helpers for the two-master round-robin bus arbiter.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;

  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_DATA_W   = 64;
  localparam int DEF_MAX_HOLD = 16;

  // Counter width able to reach MAX_HOLD-1; never narrower than one bit.
  function automatic int hold_width(input int max_hold);
    int w;
    w = $clog2(max_hold + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic owner_t owner_of(input arb_state_t s);
    owner_t o;
    case (s)
      GNT0:    o = OWN_M0;
      GNT1:    o = OWN_M1;
      default: o = OWN_NONE;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/rr_grant_fsm.sv
// Sequential arbitration core: owner state, tenure counter and round-robin history.
module rr_grant_fsm
  import bus_pkg::*;
#(
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int HOLD_W   = hold_width(MAX_HOLD)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m1_req,
  output logic [1:0]        state,
  output logic [HOLD_W-1:0] hold_cnt,
  output logic              last_owner
);

  localparam bit              HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? {HOLD_W{1'b0}} : HOLD_W'(MAX_HOLD - 1);

  arb_state_t        state_r;
  arb_state_t        state_nxt_s;
  logic [HOLD_W-1:0] hold_r;
  logic [HOLD_W-1:0] hold_nxt_s;
  logic              last_r;
  logic              last_nxt_s;
  logic              hold_expired_s;
  logic              other_req_s;

  // Tenure limit reached and the waiting master is still asking.
  always_comb begin
    hold_expired_s = HOLD_EN && (hold_r == HOLD_LAST);
    other_req_s    = 1'b0;
    case (state_r)
      GNT0:    other_req_s = m1_req;
      GNT1:    other_req_s = m0_req;
      default: other_req_s = 1'b0;
    endcase
  end

  // Next owner; last_r=1 means m1 owned last, so m0 wins a tie.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (m0_req && m1_req) begin
          state_nxt_s = last_r ? GNT0 : GNT1;
        end else if (m0_req) begin
          state_nxt_s = GNT0;
        end else if (m1_req) begin
          state_nxt_s = GNT1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GNT0: begin
        if (!m0_req) begin
          state_nxt_s = m1_req ? GNT1 : IDLE;
        end else if (m1_req && hold_expired_s) begin
          state_nxt_s = GNT1;
        end else begin
          state_nxt_s = GNT0;
        end
      end
      GNT1: begin
        if (!m1_req) begin
          state_nxt_s = m0_req ? GNT0 : IDLE;
        end else if (m0_req && hold_expired_s) begin
          state_nxt_s = GNT0;
        end else begin
          state_nxt_s = GNT1;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Counter restarts on every owner change and only counts contested cycles.
  always_comb begin
    hold_nxt_s = hold_r;
    last_nxt_s = last_r;
    if (state_nxt_s != state_r) begin
      hold_nxt_s = {HOLD_W{1'b0}};
    end else if (HOLD_EN && other_req_s && (hold_r != HOLD_LAST)) begin
      hold_nxt_s = hold_r + {{(HOLD_W-1){1'b0}}, 1'b1};
    end else begin
      hold_nxt_s = hold_r;
    end
    if ((state_nxt_s == GNT0) && (state_r != GNT0)) begin
      last_nxt_s = 1'b0;
    end else if ((state_nxt_s == GNT1) && (state_r != GNT1)) begin
      last_nxt_s = 1'b1;
    end else begin
      last_nxt_s = last_r;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      hold_r  <= {HOLD_W{1'b0}};
      last_r  <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      hold_r  <= hold_nxt_s;
      last_r  <= last_nxt_s;
    end
  end

  assign state      = state_r;
  assign hold_cnt   = hold_r;
  assign last_owner = last_r;

endmodule

// File: rtl/rr_bus_arbiter.sv
// Two-master round-robin arbiter with master->slave request mux and slave->master read return.
module rr_bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_dout,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_dout,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              m0_grant,
  output logic              m1_grant,
  output logic              s_wr,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_din,
  output logic [DATA_W-1:0] m0_din,
  output logic [DATA_W-1:0] m1_din,
  output logic              bus_busy
);

  localparam int HOLD_W = hold_width(MAX_HOLD);

  logic [1:0]        state_s;
  logic [HOLD_W-1:0] hold_cnt_s;
  logic              last_owner_s;
  owner_t            rd_owner_r;
  logic              unused_s;

  rr_grant_fsm #(
    .MAX_HOLD (MAX_HOLD),
    .HOLD_W   (HOLD_W)
  ) u_fsm (
    .clk        (clk),
    .reset      (reset),
    .m0_req     (m0_req),
    .m1_req     (m1_req),
    .state      (state_s),
    .hold_cnt   (hold_cnt_s),
    .last_owner (last_owner_s)
  );

  // Counter and history are internal to arbitration; not needed at the bus level.
  assign unused_s = ^{hold_cnt_s, last_owner_s};

  // Read data comes back one cycle after the address, so remember who owned that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_owner_r <= OWN_NONE;
    end else begin
      rd_owner_r <= owner_of(arb_state_t'(state_s));
    end
  end

  // Grants and slave-side mux decoded from the registered state only.
  always_comb begin
    m0_grant = 1'b0;
    m1_grant = 1'b0;
    s_wr     = 1'b0;
    s_addr   = {ADDR_W{1'b0}};
    s_din    = {DATA_W{1'b0}};
    case (state_s)
      GNT0: begin
        m0_grant = 1'b1;
        s_wr     = m0_wr;
        s_addr   = m0_addr;
        s_din    = m0_dout;
      end
      GNT1: begin
        m1_grant = 1'b1;
        s_wr     = m1_wr;
        s_addr   = m1_addr;
        s_din    = m1_dout;
      end
      default: begin
        m0_grant = 1'b0;
        m1_grant = 1'b0;
      end
    endcase
    bus_busy = m0_grant | m1_grant;
  end

  // Read data return steered by the previous-cycle owner.
  always_comb begin
    m0_din = {DATA_W{1'b0}};
    m1_din = {DATA_W{1'b0}};
    case (rd_owner_r)
      OWN_M0:  m0_din = s_rdata;
      OWN_M1:  m1_din = s_rdata;
      default: m0_din = {DATA_W{1'b0}};
    endcase
  end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural arbiter model.
module tb_rr_bus_arbiter;

  localparam int MH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m0_wr = 1'b0, m1_req = 1'b0, m1_wr = 1'b0;
  logic [15:0] m0_addr = 16'h0, m1_addr = 16'h0, s_addr;
  logic [63:0] m0_dout = 64'h0, m1_dout = 64'h0, s_rdata = 64'h0;
  logic        m0_grant, m1_grant, s_wr, bus_busy;
  logic [63:0] s_din, m0_din, m1_din;

  int vectors = 0;
  int fails   = 0;

  // Model: owner 0=none, 1=m0, 2=m1; contested = cycles of this tenure the other master waited.
  int m_owner = 0;
  int m_last  = 2;
  int m_cont  = 0;
  int m_prev  = 0;

  rr_bus_arbiter #(.ADDR_W(16), .DATA_W(64), .MAX_HOLD(MH)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_dout(m0_dout),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_dout(m1_dout),
    .s_rdata(s_rdata),
    .m0_grant(m0_grant), .m1_grant(m1_grant),
    .s_wr(s_wr), .s_addr(s_addr), .s_din(s_din),
    .m0_din(m0_din), .m1_din(m1_din), .bus_busy(bus_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_last = 2; m_cont = 0; m_prev = 0;
  endtask

  task automatic model_step();
    int nxt;
    bit mine, other;
    nxt = m_owner;
    if (m_owner == 0) begin
      if (m0_req && m1_req) nxt = (m_last == 2) ? 1 : 2;
      else if (m0_req)      nxt = 1;
      else if (m1_req)      nxt = 2;
      else                  nxt = 0;
      other = 1'b0;
    end else begin
      mine  = (m_owner == 1) ? m0_req : m1_req;
      other = (m_owner == 1) ? m1_req : m0_req;
      if (!mine)                                         nxt = other ? 3 - m_owner : 0;
      else if (other && MH != 0 && m_cont + 1 >= MH)     nxt = 3 - m_owner;
      else                                               nxt = m_owner;
    end
    m_prev = m_owner;
    if (nxt != m_owner) begin
      m_cont = 0;
      if (nxt != 0) m_last = nxt;
    end else if (m_owner != 0 && other) begin
      m_cont++;
    end
    m_owner = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic clear_inputs();
    m0_req = 1'b0; m1_req = 1'b0; m0_wr = 1'b0; m1_wr = 1'b0;
    m0_addr = 16'h0; m1_addr = 16'h0; m0_dout = 64'h0; m1_dout = 64'h0; s_rdata = 64'h0;
  endtask

  // Per-cycle comparison of every output against the model, half a cycle after the edge.
  initial begin
    forever begin
      @(negedge clk);
      check("m0_grant", m0_grant, (m_owner == 1) ? 64'd1 : 64'd0);
      check("m1_grant", m1_grant, (m_owner == 2) ? 64'd1 : 64'd0);
      check("bus_busy", bus_busy, (m_owner != 0) ? 64'd1 : 64'd0);
      check("s_wr",   s_wr,   (m_owner == 1) ? 64'(m0_wr)   : (m_owner == 2) ? 64'(m1_wr)   : 64'd0);
      check("s_addr", s_addr, (m_owner == 1) ? 64'(m0_addr) : (m_owner == 2) ? 64'(m1_addr) : 64'd0);
      check("s_din",  s_din,  (m_owner == 1) ? m0_dout      : (m_owner == 2) ? m1_dout      : 64'd0);
      check("m0_din", m0_din, (m_prev == 1) ? s_rdata : 64'd0);
      check("m1_din", m1_din, (m_prev == 2) ? s_rdata : 64'd0);
    end
  end

  initial begin
    int cnt;
    clear_inputs();
    reset_dut();
    check("reset_busy", bus_busy, 64'd0);

    // Single requester, then async reset in the middle of its tenure.
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 16'h0010; m0_dout = 64'h1234_5678_9ABC_DEF0;
    tick();
    check("t2_m0_grant", m0_grant, 64'd1);
    check("t2_m1_grant", m1_grant, 64'd0);
    check("t2_s_addr", s_addr, 64'h0010);
    check("t2_s_wr", s_wr, 64'd1);
    check("t2_model_owner", 64'(m_owner), 64'd1);
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    check("t1_grant_drop", m0_grant, 64'd0);
    check("t1_s_wr_drop", s_wr, 64'd0);
    check("t1_s_addr_drop", s_addr, 64'd0);
    check("t1_s_din_drop", s_din, 64'd0);
    clear_inputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    check("t1_idle_busy", bus_busy, 64'd0);

    // Simultaneous requests from reset: m0 first, m1 immediately on release.
    reset_dut();
    m0_req = 1'b1; m1_req = 1'b1;
    tick();
    check("t3_first_m0", m0_grant, 64'd1);
    check("t3_first_m1", m1_grant, 64'd0);
    m0_req = 1'b0;
    tick();
    check("t3_next_m1", m1_grant, 64'd1);
    check("t3_next_m0", m0_grant, 64'd0);

    // Hold timeout: m0 keeps the bus exactly MH cycles once m1 starts waiting.
    clear_inputs();
    reset_dut();
    m0_req = 1'b1;
    tick();
    m1_req = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!m0_grant) break;
      cnt++;
      tick();
    end
    check("t4_hold_cycles", 64'(cnt), 64'd4);
    check("t4_handover", m1_grant, 64'd1);
    check("t4_model_owner", 64'(m_owner), 64'd2);

    // Read return goes to the previous-cycle owner.
    clear_inputs();
    reset_dut();
    m1_req = 1'b1; m1_addr = 16'h0008;
    tick();
    check("t5_grant", m1_grant, 64'd1);
    check("t5_addr", s_addr, 64'h0008);
    m1_req = 1'b0;
    s_rdata = 64'hDEAD_BEEF_0000_0001;
    tick();
    check("t5_m1_din", m1_din, 64'hDEAD_BEEF_0000_0001);
    check("t5_m0_din", m0_din, 64'd0);

    // Each owner releases after one cycle while the other keeps asking: strict alternation.
    clear_inputs();
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      m0_req = (m_owner != 1);
      m1_req = (m_owner != 2);
      tick();
      check("t6_alt_m0", m0_grant, (i % 2 == 0) ? 64'd1 : 64'd0);
      check("t6_alt_m1", m1_grant, (i % 2 == 1) ? 64'd1 : 64'd0);
    end

    // Random traffic against the model.
    clear_inputs();
    reset_dut();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) m0_req = ~m0_req;
      if ($urandom_range(0, 3) == 0) m1_req = ~m1_req;
      m0_wr   = 1'($urandom);
      m1_wr   = 1'($urandom);
      m0_addr = 16'($urandom);
      m1_addr = 16'($urandom);
      m0_dout = {$urandom, $urandom};
      m1_dout = {$urandom, $urandom};
      s_rdata = {$urandom, $urandom};
      tick();
      if (i == 1000) begin
        clear_inputs();
        reset_dut();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
